// File: rtl/buzzer_tone.sv
// buzzer_tone: bus-mapped square-wave buzzer driver with a one-deep
// note queue, continuous mode and sticky done/overflow status.
module buzzer_tone #(
  parameter int PERIOD_WIDTH   = 24,
  parameter int DURATION_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic [3:2]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_in,
  input  logic [3:0]  data_strobes,
  output logic [31:0] data_out,
  output logic        buzzer,
  output logic        busy
);

  localparam int PW = PERIOD_WIDTH;
  localparam int DW = DURATION_WIDTH;
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [DW-1:0] D_ONE = 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t state_q, state_d;

  logic [PW-1:0] period_q;
  logic [DW-1:0] duration_q;
  logic          cont_q;

  logic [PW-1:0] act_period_q, act_period_d;
  logic          act_cont_q, act_cont_d;
  logic [PW-1:0] half_q, half_d;
  logic [DW-1:0] rem_q, rem_d;

  logic          pend_valid_q, pend_valid_d;
  logic [PW-1:0] pend_period_q, pend_period_d;
  logic [DW-1:0] pend_duration_q, pend_duration_d;
  logic          pend_cont_q, pend_cont_d;

  logic done_q, overflow_q;
  logic buzz_d;

  logic wr, rd, rd_status;
  logic wr_period, wr_duration, ctl_wr;
  logic cmd_stop, cmd_start, cont_new, start_ok;
  logic half_zero, note_end;
  logic launch, to_pend, done_set, ovf_set;

  logic [31:0] byte_mask, period_mrg, duration_mrg, rd_data;
  logic        unused_bits;

  assign wr          = cs & write;
  assign rd          = cs & read;
  assign rd_status   = rd & (address == 2'd3);
  assign wr_period   = wr & (address == 2'd0);
  assign wr_duration = wr & (address == 2'd1);
  assign ctl_wr      = wr & (address == 2'd2) & data_strobes[0];

  assign byte_mask = {{8{data_strobes[3]}}, {8{data_strobes[2]}},
                      {8{data_strobes[1]}}, {8{data_strobes[0]}}};

  assign period_mrg   = (32'(period_q) & ~byte_mask)
                      | (data_in & byte_mask);
  assign duration_mrg = (32'(duration_q) & ~byte_mask)
                      | (data_in & byte_mask);
  assign unused_bits  = ^{period_mrg, duration_mrg};

  // STOP dominates START within one CONTROL write
  assign cmd_stop  = ctl_wr & data_in[1];
  assign cmd_start = ctl_wr & data_in[0] & ~data_in[1];
  assign cont_new  = ctl_wr ? data_in[2] : cont_q;
  assign start_ok  = cmd_start & (period_q != '0)
                   & ((duration_q != '0) | cont_new);

  assign busy      = (state_q == PLAY);
  assign half_zero = (half_q == '0);
  assign note_end  = busy & half_zero & ~act_cont_q & (rem_q == D_ONE);

  assign launch   = start_ok
                  & (~busy | (note_end & ~pend_valid_q));
  assign to_pend  = start_ok & busy & ~pend_valid_q & ~note_end;
  assign ovf_set  = start_ok & busy & pend_valid_q;
  assign done_set = note_end & ~pend_valid_q & ~cmd_stop;

  always_comb begin
    rd_data = '0;
    unique case (address)
      2'd0: rd_data = 32'(period_q);
      2'd1: rd_data = 32'(duration_q);
      2'd2: rd_data = {29'b0, cont_q, 2'b0};
      2'd3: rd_data = {28'b0, overflow_q, pend_valid_q, done_q, busy};
    endcase
  end

  always_comb begin
    state_d         = state_q;
    buzz_d          = buzzer;
    half_d          = half_q;
    rem_d           = rem_q;
    act_period_d    = act_period_q;
    act_cont_d      = act_cont_q;
    pend_valid_d    = pend_valid_q;
    pend_period_d   = pend_period_q;
    pend_duration_d = pend_duration_q;
    pend_cont_d     = pend_cont_q;
    if (cmd_stop) begin
      state_d         = IDLE;
      buzz_d          = 1'b0;
      half_d          = '0;
      rem_d           = '0;
      act_period_d    = '0;
      act_cont_d      = 1'b0;
      pend_valid_d    = 1'b0;
      pend_period_d   = '0;
      pend_duration_d = '0;
      pend_cont_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (!half_zero) begin
            half_d = half_q - P_ONE;
          end else if (!note_end) begin
            buzz_d = ~buzzer;
            half_d = act_period_q - P_ONE;
            if (!act_cont_q) rem_d = rem_q - D_ONE;
          end else if (pend_valid_q) begin
            // back-to-back handoff: no silent cycle between notes
            buzz_d          = 1'b1;
            act_period_d    = pend_period_q;
            act_cont_d      = pend_cont_q;
            half_d          = pend_period_q - P_ONE;
            rem_d           = pend_duration_q;
            pend_valid_d    = 1'b0;
            pend_period_d   = '0;
            pend_duration_d = '0;
            pend_cont_d     = 1'b0;
          end else begin
            state_d      = IDLE;
            buzz_d       = 1'b0;
            half_d       = '0;
            rem_d        = '0;
            act_period_d = '0;
            act_cont_d   = 1'b0;
          end
        end
      endcase
      if (to_pend) begin
        pend_valid_d    = 1'b1;
        pend_period_d   = period_q;
        pend_duration_d = duration_q;
        pend_cont_d     = cont_new;
      end
      if (launch) begin
        state_d      = PLAY;
        buzz_d       = 1'b1;
        act_period_d = period_q;
        act_cont_d   = cont_new;
        half_d       = period_q - P_ONE;
        rem_d        = duration_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      buzzer          <= 1'b0;
      half_q          <= '0;
      rem_q           <= '0;
      act_period_q    <= '0;
      act_cont_q      <= 1'b0;
      pend_valid_q    <= 1'b0;
      pend_period_q   <= '0;
      pend_duration_q <= '0;
      pend_cont_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      buzzer          <= buzz_d;
      half_q          <= half_d;
      rem_q           <= rem_d;
      act_period_q    <= act_period_d;
      act_cont_q      <= act_cont_d;
      pend_valid_q    <= pend_valid_d;
      pend_period_q   <= pend_period_d;
      pend_duration_q <= pend_duration_d;
      pend_cont_q     <= pend_cont_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_q   <= '0;
      duration_q <= '0;
      cont_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_out   <= '0;
    end else begin
      if (wr_period)   period_q   <= period_mrg[PW-1:0];
      if (wr_duration) duration_q <= duration_mrg[DW-1:0];
      if (ctl_wr)      cont_q     <= data_in[2];
      if (rd)          data_out   <= rd_data;
      // a new event on the read edge survives the clear
      if (done_set)       done_q <= 1'b1;
      else if (rd_status) done_q <= 1'b0;
      if (ovf_set)        overflow_q <= 1'b1;
      else if (rd_status) overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buzzer_tone.sv
// tb_buzzer_tone: directed and random stimulus against a note-level
// model that derives the waveform from elapsed time within each note.
module tb_buzzer_tone;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic [3:2]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  data_strobes = '0;
  logic [31:0] data_out;
  logic        buzzer;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  buzzer_tone dut (
    .clock(clock), .reset(reset), .cs(cs), .address(address),
    .read(read), .write(write), .data_in(data_in),
    .data_strobes(data_strobes), .data_out(data_out),
    .buzzer(buzzer), .busy(busy)
  );

  always #5 clock = ~clock;

  // model state: a note is (period, duration, cont) plus elapsed cycles
  logic [31:0] m_period, m_duration, m_dout;
  bit m_cont, m_busy, m_pv, m_done, m_ovf;
  int m_e, m_ap, m_ad;
  bit m_ac;
  int m_pp, m_pd;
  bit m_pc;

  function automatic bit m_buzz();
    if (!m_busy) return 1'b0;
    return ((m_e / m_ap) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_period = 0; m_duration = 0; m_dout = 0;
    m_cont = 0; m_busy = 0; m_pv = 0; m_done = 0; m_ovf = 0;
    m_e = 0; m_ap = 0; m_ad = 0; m_ac = 0;
    m_pp = 0; m_pd = 0; m_pc = 0;
  endtask

  task automatic model_edge();
    bit wr, rd, rds, ctl, stop, start, ncont, ok, ends;
    bit old_busy, old_pv, dset, oset;
    logic [31:0] v;
    wr = cs && write;
    rd = cs && read;
    rds = rd && address == 2'd3;
    if (rd) begin
      case (address)
        2'd0: m_dout = m_period;
        2'd1: m_dout = m_duration;
        2'd2: m_dout = {29'b0, m_cont, 2'b0};
        default: m_dout = {28'b0, m_ovf, m_pv, m_done, m_busy};
      endcase
    end
    ctl = wr && address == 2'd2 && data_strobes[0];
    stop = ctl && data_in[1];
    start = ctl && data_in[0] && !data_in[1];
    ncont = ctl ? data_in[2] : m_cont;
    ok = start && m_period != 0 && (m_duration != 0 || ncont);
    ends = m_busy && !m_ac && m_e == m_ad * m_ap - 1;
    old_busy = m_busy;
    old_pv = m_pv;
    dset = 0;
    oset = 0;
    if (stop) begin
      m_busy = 0; m_pv = 0; m_e = 0;
    end else begin
      if (m_busy) begin
        if (ends && m_pv) begin
          m_ap = m_pp; m_ad = m_pd; m_ac = m_pc; m_e = 0; m_pv = 0;
        end else if (ends) begin
          m_busy = 0; dset = 1;
        end else m_e++;
      end
      if (ok) begin
        if (!old_busy || (ends && !old_pv)) begin
          m_ap = m_period; m_ad = m_duration; m_ac = ncont;
          m_e = 0; m_busy = 1;
        end else if (old_pv) oset = 1;
        else begin
          m_pp = m_period; m_pd = m_duration; m_pc = ncont; m_pv = 1;
        end
      end
    end
    m_done = dset || (m_done && !rds);
    m_ovf = oset || (m_ovf && !rds);
    if (wr && address != 2'd2 && address != 2'd3) begin
      v = address == 2'd0 ? m_period : m_duration;
      for (int i = 0; i < 4; i++)
        if (data_strobes[i]) v[8*i +: 8] = data_in[8*i +: 8];
      if (address == 2'd0) m_period = v & 32'h00FF_FFFF;
      else m_duration = v & 32'h0000_FFFF;
    end
    if (ctl) m_cont = data_in[2];
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("buzzer", 32'(buzzer), 32'(m_buzz()));
    check("busy", 32'(busy), 32'(m_busy));
    check("data_out", data_out, m_dout);
    cs = 0; read = 0; write = 0; data_strobes = '0; data_in = '0;
  endtask

  task automatic wr_be(input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    cs = 1; write = 1; address = a; data_in = d; data_strobes = be;
    step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_be(a, d, 4'hF);
  endtask

  task automatic rd(input logic [1:0] a);
    cs = 1; read = 1; address = a;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    int cnt, tog;
    bit all_busy, prev;
    logic [1:0] a;
    logic [3:0] be;
    int r;

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_buzzer", 32'(buzzer), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data_out", data_out, 32'd0);
    reset = 0;

    // 4x4 note: two full square periods
    wr(2'd0, 4);
    wr(2'd1, 4);
    wr(2'd2, 1);
    pat[15] = buzzer;
    for (int i = 14; i >= 0; i--) begin
      step();
      pat[i] = buzzer;
    end
    check("note44_pattern", 32'(pat), 32'h0000_F0F0);
    step();
    check("note44_end_busy", 32'(busy), 32'd0);
    rd(2'd3);
    check("status_done", data_out, 32'h2);
    rd(2'd3);
    check("status_cleared", data_out, 32'h0);

    // queued note and overflow
    wr(2'd0, 2);
    wr(2'd1, 3);
    wr(2'd2, 1);
    cnt = busy;
    wr(2'd0, 3);  cnt += busy;
    wr(2'd1, 2);  cnt += busy;
    wr(2'd2, 1);  cnt += busy;
    wr(2'd2, 1);  cnt += busy;
    rd(2'd3);     cnt += busy;
    check("status_ovf_pending", data_out, 32'hD);
    for (int i = 0; i < 50 && busy; i++) begin
      step();
      cnt += busy;
    end
    check("queued_busy_cycles", 32'(cnt), 32'd12);
    rd(2'd3);
    check("status_after_queue", data_out, 32'h2);

    // continuous note then STOP
    wr(2'd0, 5);
    wr(2'd2, 5);
    prev = buzzer;
    tog = 0;
    all_busy = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (buzzer != prev) tog++;
      prev = buzzer;
      all_busy &= busy;
    end
    check("cont_toggles", 32'(tog), 32'd20);
    check("cont_busy", 32'(all_busy), 32'd1);
    wr(2'd2, 2);
    check("stop_buzzer", 32'(buzzer), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    rd(2'd3);
    check("stop_status", data_out, 32'h0);

    // invalid starts and START|STOP
    wr(2'd0, 0);
    wr(2'd1, 3);
    wr(2'd2, 1);
    check("period0_busy", 32'(busy), 32'd0);
    wr(2'd0, 4);
    wr(2'd1, 0);
    wr(2'd2, 1);
    check("dur0_busy", 32'(busy), 32'd0);
    rd(2'd3);
    check("invalid_status", data_out, 32'h0);
    wr(2'd1, 3);
    wr(2'd2, 1);
    idle(2);
    wr(2'd2, 3);
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_buzzer", 32'(buzzer), 32'd0);
    rd(2'd3);
    check("startstop_status", data_out, 32'h0);

    // byte lanes, then asynchronous reset mid-note
    wr_be(2'd0, 32'hAABB_CCDD, 4'b0001);
    rd(2'd0);
    check("period_lane0", data_out, 32'h0000_00DD);
    wr(2'd1, 4);
    wr(2'd2, 1);
    idle(3);
    check("pre_reset_buzzer", 32'(buzzer), 32'd1);
    #1 reset = 1;
    #1;
    check("async_reset_buzzer", 32'(buzzer), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      rd(a);
      check("reg_after_reset", data_out, 32'h0);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      be = 4'($urandom_range(0, 15));
      if (r <= 3) step();
      else if (r == 4) wr_be(2'd0, $urandom_range(0, 4), be | 4'h1);
      else if (r == 5) wr_be(2'd1, $urandom_range(0, 5), be);
      else if (r == 6) wr_be(2'd2, $urandom_range(0, 7),
                             {be[3:1], 1'($urandom_range(0, 3) != 0)});
      else if (r <= 8) rd(2'($urandom_range(0, 3)));
      else begin
        write = 1; read = 1; address = 2'd2; data_in = 32'h1;
        data_strobes = 4'hF;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
